rgb2hsv_seq: RTL and testbench

//  Parametrised successor to the fixed 32-bit RGB->HSV datapath. Accepts one RGB pixel per

---
 rtl/hsv_pkg.sv | 26 ++
 rtl/seq_divider.sv | 77 +++++++
 rtl/rgb2hsv_seq.sv | 142 ++++++++++++++
 tb/tb_rgb2hsv_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_pkg.sv
// Shared types and constants for the sequential RGB->HSV converter.
// The FSM states, hue sectors and divider cycle count all live here.
package hsv_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DIV, DONE} state_t;
    typedef enum logic [1:0] {SEC_R, SEC_G, SEC_B} sector_t;

    localparam int unsigned HUE_SEC  = 60;
    localparam int unsigned OFF_G    = 120;
    localparam int unsigned OFF_B    = 240;
    localparam int unsigned HUE_WRAP = 360;

    // Each quotient needs at least 6 bits (hue quotient <= 60) and S_W bits for saturation.
    function automatic int unsigned div_cycles(input int unsigned s_w);
        return (s_w > 6) ? s_w : 6;
    endfunction

    function automatic int unsigned sector_offset(input sector_t sec);
        case (sec)
            SEC_G:   return OFF_G;
            SEC_B:   return OFF_B;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider producing one quotient bit per cycle, MSB first.
// Requires num < (den << Q_W); the first bit is resolved on the start edge.
module seq_divider #(
    parameter int unsigned NUM_W = 16,
    parameter int unsigned DEN_W = 8,
    parameter int unsigned Q_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [Q_W-1:0]   quo
);
    localparam int unsigned CW    = NUM_W + DEN_W + Q_W;
    localparam int unsigned CNT_W = $clog2(Q_W + 1);

    logic [NUM_W-1:0] rem_q, rem_d, step_rem, diff;
    logic [CW-1:0]    dvs_q, dvs_d, step_dvs;
    logic [Q_W-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d, done_q, done_d, step_bit;

    always_comb begin
        step_rem = start ? num : rem_q;
        step_dvs = start ? (CW'(den) << (Q_W - 1)) : dvs_q;
        step_bit = (CW'(step_rem) >= step_dvs);
        // When the bit is set the shifted divisor fits in NUM_W bits.
        diff     = step_rem - step_dvs[NUM_W-1:0];
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        done_d   = 1'b0;
        if (start) begin
            rem_d  = step_bit ? diff : step_rem;
            dvs_d  = step_dvs >> 1;
            quo_d  = {{(Q_W-1){1'b0}}, step_bit};
            cnt_d  = CNT_W'(Q_W - 1);
            run_d  = (Q_W > 1);
            done_d = (Q_W == 1);
        end else if (run_q) begin
            rem_d = step_bit ? diff : step_rem;
            dvs_d = step_dvs >> 1;
            quo_d = {quo_q[Q_W-2:0], step_bit};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign quo  = quo_q;

endmodule

// File: rtl/rgb2hsv_seq.sv
// Handshaked RGB->HSV converter: one pixel per IDLE->CALC->[DIV]->DONE pass,
// with hue and saturation quotients from two divider instances started together.
module rgb2hsv_seq
    import hsv_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned S_W   = 8,
    parameter int unsigned H_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_r,
    input  logic [PIX_W-1:0] in_g,
    input  logic [PIX_W-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [H_W-1:0]   out_h,
    output logic [S_W-1:0]   out_s,
    output logic [PIX_W-1:0] out_v,
    output logic             busy
);
    localparam int unsigned DIV_CYC = div_cycles(S_W);
    localparam int unsigned NUM_W   = PIX_W + DIV_CYC;
    localparam int unsigned S_MAX   = (1 << S_W) - 1;

    state_t           state_q, state_d;
    sector_t          sec_q, sec_d, sec;
    logic [PIX_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d, v_q, v_d;
    logic [H_W-1:0]   h_q, h_d;
    logic [S_W-1:0]   s_q, s_d;
    logic             neg_q, neg_d, neg, out_valid_q, out_valid_d;
    logic [PIX_W-1:0] cmax, cmin, delta, mag;
    logic [NUM_W-1:0] hue_num, sat_num;
    logic [DIV_CYC-1:0] hue_quo, sat_quo;
    logic             start, hue_done, sat_done;
    logic [H_W:0]     hq_ext, off_ext, h_calc;

    always_comb begin
        if (r_q >= g_q && r_q >= b_q) begin
            cmax = r_q; sec = SEC_R; neg = (g_q < b_q);
            mag  = neg ? b_q - g_q : g_q - b_q;
        end else if (g_q >= b_q) begin
            cmax = g_q; sec = SEC_G; neg = (b_q < r_q);
            mag  = neg ? r_q - b_q : b_q - r_q;
        end else begin
            cmax = b_q; sec = SEC_B; neg = (r_q < g_q);
            mag  = neg ? g_q - r_q : r_q - g_q;
        end
        cmin    = (r_q <= g_q && r_q <= b_q) ? r_q : ((g_q <= b_q) ? g_q : b_q);
        delta   = cmax - cmin;
        hue_num = NUM_W'(HUE_SEC) * NUM_W'(mag);
        sat_num = NUM_W'(delta) * NUM_W'(S_MAX);

        // Negative numerator only wraps below zero in the red sector.
        hq_ext  = (H_W+1)'(hue_quo);
        off_ext = (H_W+1)'(sector_offset(sec_q));
        if (!neg_q)
            h_calc = off_ext + hq_ext;
        else if (hq_ext > off_ext)
            h_calc = off_ext + (H_W+1)'(HUE_WRAP) - hq_ext;
        else
            h_calc = off_ext - hq_ext;
    end

    always_comb begin
        state_d     = state_q;
        r_d = r_q; g_d = g_q; b_d = b_q;
        v_d = v_q; h_d = h_q; s_d = s_q;
        sec_d       = sec_q;
        neg_d       = neg_q;
        out_valid_d = out_valid_q;
        start       = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                r_d = in_r; g_d = in_g; b_d = in_b;
                state_d = CALC;
            end
            CALC: begin
                v_d   = cmax;
                sec_d = sec;
                neg_d = neg;
                if (delta == '0) begin
                    h_d = '0; s_d = '0;
                    out_valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    start   = 1'b1;
                    state_d = DIV;
                end
            end
            DIV: if (hue_done && sat_done) begin
                h_d = h_calc[H_W-1:0];
                s_d = sat_quo[S_W-1:0];
                out_valid_d = 1'b1;
                state_d = DONE;
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    seq_divider #(.NUM_W(NUM_W), .DEN_W(PIX_W), .Q_W(DIV_CYC)) u_hue_div (
        .clk(clk), .rst(rst), .start(start), .num(hue_num), .den(delta),
        .done(hue_done), .quo(hue_quo)
    );

    seq_divider #(.NUM_W(NUM_W), .DEN_W(PIX_W), .Q_W(DIV_CYC)) u_sat_div (
        .clk(clk), .rst(rst), .start(start), .num(sat_num), .den(cmax),
        .done(sat_done), .quo(sat_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q <= '0; g_q <= '0; b_q <= '0;
            v_q <= '0; h_q <= '0; s_q <= '0;
            sec_q       <= SEC_R;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q <= r_d; g_q <= g_d; b_q <= b_d;
            v_q <= v_d; h_q <= h_d; s_q <= s_d;
            sec_q       <= sec_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_h     = h_q;
    assign out_s     = s_q;
    assign out_v     = v_q;

endmodule

// File: tb/tb_rgb2hsv_seq.sv
// Scoreboard bench for rgb2hsv_seq: directed spec vectors, back-pressure,
// mid-divide reset and randomized traffic against an integer HSV model.
module tb_rgb2hsv_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] out_h;
    logic [7:0] out_s, out_v;
    logic       busy;

    typedef struct {
        int h; int s; int v; int lat; int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   rdy_random = 1'b0;
    bit   rdy_force  = 1'b1;

    rgb2hsv_seq #(.PIX_W(8), .S_W(8), .H_W(9)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_h(out_h), .out_s(out_s), .out_v(out_v), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // HSV from the textbook definition with signed integer arithmetic.
    function automatic exp_t model(input int r, input int g, input int b);
        exp_t e;
        int mx, mn, d, off, num, q, h;
        mx = (r > g) ? r : g; mx = (mx > b) ? mx : b;
        mn = (r < g) ? r : g; mn = (mn < b) ? mn : b;
        d  = mx - mn;
        e.v = mx; e.acc_cyc = 0;
        if (d == 0) begin
            e.h = 0; e.s = 0; e.lat = 2;
        end else begin
            if (r == mx)      begin off = 0;   num = g - b; end
            else if (g == mx) begin off = 120; num = b - r; end
            else              begin off = 240; num = r - g; end
            q = (60 * ((num < 0) ? -num : num)) / d;
            h = off + ((num < 0) ? -q : q);
            if (h < 0) h += 360;
            e.h = h; e.s = (d * 255) / mx; e.lat = 10;
        end
        return e;
    endfunction

    task automatic send_exp(input int r, input int g, input int b, input exp_t e);
        int n = 0;
        exp_t x = e;
        @(posedge clk); #1;
        in_valid = 1'b1; in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        x.acc_cyc = cyc;
        sb.push_back(x);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_r = 8'($urandom_range(0, 255));
        in_g = 8'($urandom_range(0, 255));
        in_b = 8'($urandom_range(0, 255));
    endtask

    task automatic send(input int r, input int g, input int b);
        send_exp(r, g, b, model(r, g, b));
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = rdy_random ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    initial begin
        logic        pv = 1'b0;
        logic [31:0] held = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                continue;
            end
            if (out_valid && !pv) begin
                if (sb.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
                else chk("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
            end else if (out_valid && pv) begin
                chk("hold_stable", {7'd0, out_h, out_s, out_v}, held);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_h", 32'(out_h), 32'(e.h));
                chk("out_s", 32'(out_s), 32'(e.s));
                chk("out_v", 32'(out_v), 32'(e.v));
            end
            pv   = out_valid;
            held = {7'd0, out_h, out_s, out_v};
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        typedef struct { int r; int g; int b; int h; int s; int v; int lat; } vec_t;
        vec_t dir[8] = '{
            '{255,   0,   0,   0, 255, 255, 10},
            '{  0, 255,   0, 120, 255, 255, 10},
            '{  0,   0, 255, 240, 255, 255, 10},
            '{200, 100,  50,  20, 191, 200, 10},
            '{255,   0, 128, 330, 255, 255, 10},
            '{100, 100, 100,   0,   0, 100,  2},
            '{  0,   0,   0,   0,   0,   0,  2},
            '{255, 255,   0,  60, 255, 255, 10}
        };
        exp_t e;
        int   n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_outputs", {7'd0, out_h, out_s, out_v}, 32'd0);

        foreach (dir[i]) begin
            e = '{h: dir[i].h, s: dir[i].s, v: dir[i].v, lat: dir[i].lat, acc_cyc: 0};
            send_exp(dir[i].r, dir[i].g, dir[i].b, e);
            drain();
        end

        // Back-pressure: hold DONE for five cycles while offering junk pixels.
        rdy_force = 1'b0;
        @(negedge clk);
        e = '{h: 20, s: 191, v: 200, lat: 10, acc_cyc: 0};
        send_exp(200, 100, 50, e);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_r = 8'($urandom_range(0, 255));
            in_g = 8'($urandom_range(0, 255));
            in_b = 8'($urandom_range(0, 255));
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        rdy_force = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Reset during the third divide cycle discards the pixel.
        send(255, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_outputs", {7'd0, out_h, out_s, out_v}, 32'd0);
        sb.delete();
        repeat (12) begin
            @(negedge clk);
            chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end
        e = '{h: 210, s: 170, v: 30, lat: 10, acc_cyc: 0};
        send_exp(10, 20, 30, e);
        drain();

        // Randomized traffic with gaps on both sides.
        rdy_random = 1'b1;
        for (int unsigned k = 0; k < 3000; k++) begin
            int r, g, b;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            r = $urandom_range(0, 255);
            g = ($urandom_range(0, 7) == 0) ? r : $urandom_range(0, 255);
            b = ($urandom_range(0, 7) == 0) ? g : $urandom_range(0, 255);
            send(r, g, b);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
